// File: rtl/mem_pipe_stage.sv
// mem_pipe_stage: memory-access pipeline stage. Non-memory instructions pass
// through with one cycle of latency. Aligned loads and stores park in WAIT
// and hold upstream until the memory acks or the wait budget runs out.
// Misaligned accesses become exception bubbles without touching memory.
module mem_pipe_stage #(
  parameter int TNEW_W   = 3,
  parameter int MAX_WAIT = 15
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              flush,
  input  logic              stall_in,
  input  logic              in_valid,
  input  logic [3:0]        in_op,
  input  logic [31:0]       in_pc,
  input  logic [31:0]       in_addr,
  input  logic [31:0]       in_wdata,
  input  logic [31:0]       in_wd,
  input  logic [4:0]        in_rt,
  input  logic [4:0]        in_wa,
  input  logic [TNEW_W-1:0] in_tnew,
  input  logic [4:0]        fwd_addr,
  input  logic [31:0]       fwd_data,
  output logic              stall_out,
  output logic              mem_req,
  output logic [31:0]       mem_addr,
  output logic [31:0]       mem_wdata,
  output logic [3:0]        mem_we,
  input  logic              mem_ack,
  input  logic [31:0]       mem_rdata,
  output logic              out_valid,
  output logic [31:0]       out_pc,
  output logic [4:0]        out_wa,
  output logic [31:0]       out_wd,
  output logic [TNEW_W-1:0] out_tnew,
  output logic [1:0]        out_exc
);

  localparam logic [0:0] S_IDLE = 1'b0;
  localparam logic [0:0] S_WAIT = 1'b1;

  localparam logic [3:0] OP_LB  = 4'd1;
  localparam logic [3:0] OP_LBU = 4'd2;
  localparam logic [3:0] OP_LH  = 4'd3;
  localparam logic [3:0] OP_LHU = 4'd4;
  localparam logic [3:0] OP_LW  = 4'd5;
  localparam logic [3:0] OP_SB  = 4'd6;
  localparam logic [3:0] OP_SH  = 4'd7;
  localparam logic [3:0] OP_SW  = 4'd8;

  localparam logic [7:0] MAX_W = 8'(MAX_WAIT);

  function automatic logic [TNEW_W-1:0] tdec(input logic [TNEW_W-1:0] t);
    return (t == '0) ? '0 : t - TNEW_W'(1);
  endfunction

  logic [0:0]        state_q, state_d;
  logic [7:0]        cnt_q, cnt_d;
  logic              kill_q, kill_d;
  logic              got_q, got_d;
  logic [31:0]       rdata_q, rdata_d;
  logic [3:0]        op_q, op_d;
  logic [31:0]       addr_q, addr_d;
  logic [31:0]       sdata_q, sdata_d;
  logic [4:0]        wa_q, wa_d;
  logic [31:0]       pc_q, pc_d;
  logic [TNEW_W-1:0] tnew_q, tnew_d;

  logic              out_valid_q, out_valid_d;
  logic [31:0]       out_pc_q, out_pc_d;
  logic [4:0]        out_wa_q, out_wa_d;
  logic [31:0]       out_wd_q, out_wd_d;
  logic [TNEW_W-1:0] out_tnew_q, out_tnew_d;
  logic [1:0]        out_exc_q, out_exc_d;

  logic        in_mem, in_load, in_aligned;
  logic        wait_st, timeout, req, ack_now, done;
  logic [31:0] rd_sel, ld_val, st_data;
  logic [7:0]  lane_b;
  logic [15:0] lane_h;
  logic [3:0]  we_raw;
  logic        st_q;

  // Decode the incoming instruction: memory op, load vs store, alignment
  always_comb begin
    in_mem     = in_valid && (in_op >= OP_LB) && (in_op <= OP_SW);
    in_load    = (in_op <= OP_LW);
    in_aligned = 1'b1;
    case (in_op)
      OP_LH, OP_LHU, OP_SH: in_aligned = ~in_addr[0];
      OP_LW, OP_SW:         in_aligned = (in_addr[1:0] == 2'b00);
      default:              in_aligned = 1'b1;
    endcase
  end

  assign wait_st = (state_q == S_WAIT);
  // Once an ack has been captured the request is finished; the counter only
  // matters while we are still asking.
  assign timeout = wait_st && !got_q && (cnt_q >= MAX_W);
  assign req     = wait_st && !got_q && !timeout;
  assign ack_now = req && mem_ack;
  assign done    = wait_st && !stall_in && (got_q || ack_now || timeout);
  assign rd_sel  = got_q ? rdata_q : mem_rdata;
  assign st_q    = (op_q >= OP_SB);

  // Lane extraction and extension of the load result
  always_comb begin
    case (addr_q[1:0])
      2'd1:    lane_b = rd_sel[15:8];
      2'd2:    lane_b = rd_sel[23:16];
      2'd3:    lane_b = rd_sel[31:24];
      default: lane_b = rd_sel[7:0];
    endcase
    lane_h = addr_q[1] ? rd_sel[31:16] : rd_sel[15:0];
    case (op_q)
      OP_LB:   ld_val = {{24{lane_b[7]}}, lane_b};
      OP_LBU:  ld_val = {24'b0, lane_b};
      OP_LH:   ld_val = {{16{lane_h[15]}}, lane_h};
      OP_LHU:  ld_val = {16'b0, lane_h};
      OP_LW:   ld_val = rd_sel;
      default: ld_val = '0;
    endcase
  end

  // Byte enables and replicated store data for the latched store
  always_comb begin
    we_raw  = 4'b0000;
    st_data = sdata_q;
    case (op_q)
      OP_SB: begin
        we_raw  = 4'b0001 << addr_q[1:0];
        st_data = {4{sdata_q[7:0]}};
      end
      OP_SH: begin
        we_raw  = addr_q[1] ? 4'b1100 : 4'b0011;
        st_data = {2{sdata_q[15:0]}};
      end
      OP_SW:   we_raw = 4'b1111;
      default: we_raw = 4'b0000;
    endcase
  end

  // Reset gates the handshake outputs so a request dies in the reset cycle
  always_comb begin
    mem_req   = !reset && req;
    mem_we    = mem_req ? we_raw : 4'b0000;
    mem_addr  = {addr_q[31:2], 2'b00};
    mem_wdata = st_data;
    stall_out = !reset && (wait_st ? !done
                                   : (stall_in || (in_mem && in_aligned && !flush)));
  end

  // Next-state: FSM, transaction latches and output registers
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    kill_d      = kill_q;
    got_d       = got_q;
    rdata_d     = rdata_q;
    op_d        = op_q;
    addr_d      = addr_q;
    sdata_d     = sdata_q;
    wa_d        = wa_q;
    pc_d        = pc_q;
    tnew_d      = tnew_q;
    out_valid_d = out_valid_q;
    out_pc_d    = out_pc_q;
    out_wa_d    = out_wa_q;
    out_wd_d    = out_wd_q;
    out_tnew_d  = out_tnew_q;
    out_exc_d   = out_exc_q;
    if (!wait_st) begin
      if (flush) begin
        out_valid_d = 1'b0;
        out_pc_d    = '0;
        out_wa_d    = '0;
        out_wd_d    = '0;
        out_tnew_d  = '0;
        out_exc_d   = 2'b00;
      end else if (!stall_in) begin
        if (in_mem && in_aligned) begin
          state_d     = S_WAIT;
          cnt_d       = '0;
          kill_d      = 1'b0;
          got_d       = 1'b0;
          op_d        = in_op;
          addr_d      = in_addr;
          sdata_d     = ((fwd_addr == in_rt) && (fwd_addr != 5'd0)) ? fwd_data : in_wdata;
          wa_d        = in_wa;
          pc_d        = in_pc;
          tnew_d      = in_tnew;
          // downstream sees bubbles while the access is outstanding
          out_valid_d = 1'b0;
          out_pc_d    = '0;
          out_wa_d    = '0;
          out_wd_d    = '0;
          out_tnew_d  = '0;
          out_exc_d   = 2'b00;
        end else if (in_mem) begin
          out_valid_d = 1'b1;
          out_pc_d    = in_pc;
          out_wa_d    = '0;
          out_wd_d    = '0;
          out_tnew_d  = tdec(in_tnew);
          out_exc_d   = in_load ? 2'b01 : 2'b10;
        end else begin
          out_valid_d = in_valid;
          out_pc_d    = in_pc;
          out_wa_d    = in_wa;
          out_wd_d    = in_wd;
          out_tnew_d  = tdec(in_tnew);
          out_exc_d   = 2'b00;
        end
      end
    end else begin
      if (flush) kill_d = 1'b1;
      if (ack_now && stall_in) begin
        got_d   = 1'b1;
        rdata_d = mem_rdata;
      end else if (req && !mem_ack) begin
        cnt_d = cnt_q + 8'd1;
      end
      if (done) begin
        state_d = S_IDLE;
        kill_d  = 1'b0;
        got_d   = 1'b0;
        if (kill_q || flush) begin
          out_valid_d = 1'b0;
          out_pc_d    = '0;
          out_wa_d    = '0;
          out_wd_d    = '0;
          out_tnew_d  = '0;
          out_exc_d   = 2'b00;
        end else begin
          out_valid_d = 1'b1;
          out_pc_d    = pc_q;
          out_tnew_d  = tdec(tnew_q);
          if (timeout) begin
            out_wa_d  = '0;
            out_wd_d  = '0;
            out_exc_d = 2'b11;
          end else begin
            out_wa_d  = st_q ? 5'd0 : wa_q;
            out_wd_d  = st_q ? 32'd0 : ld_val;
            out_exc_d = 2'b00;
          end
        end
      end
    end
  end

  // State registers with synchronous reset
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      kill_q      <= 1'b0;
      got_q       <= 1'b0;
      rdata_q     <= '0;
      op_q        <= '0;
      addr_q      <= '0;
      sdata_q     <= '0;
      wa_q        <= '0;
      pc_q        <= '0;
      tnew_q      <= '0;
      out_valid_q <= 1'b0;
      out_pc_q    <= '0;
      out_wa_q    <= '0;
      out_wd_q    <= '0;
      out_tnew_q  <= '0;
      out_exc_q   <= 2'b00;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      kill_q      <= kill_d;
      got_q       <= got_d;
      rdata_q     <= rdata_d;
      op_q        <= op_d;
      addr_q      <= addr_d;
      sdata_q     <= sdata_d;
      wa_q        <= wa_d;
      pc_q        <= pc_d;
      tnew_q      <= tnew_d;
      out_valid_q <= out_valid_d;
      out_pc_q    <= out_pc_d;
      out_wa_q    <= out_wa_d;
      out_wd_q    <= out_wd_d;
      out_tnew_q  <= out_tnew_d;
      out_exc_q   <= out_exc_d;
    end
  end

  assign out_valid = out_valid_q;
  assign out_pc    = out_pc_q;
  assign out_wa    = out_wa_q;
  assign out_wd    = out_wd_q;
  assign out_tnew  = out_tnew_q;
  assign out_exc   = out_exc_q;

endmodule

// File: tb/tb_mem_pipe_stage.sv
// tb_mem_pipe_stage: directed scenarios plus randomized traffic, checked every
// cycle against a transaction-level reference model of the stage.
module tb_mem_pipe_stage;
  localparam int TW = 3;
  localparam int MW = 4;

  logic          clk, reset, flush, stall_in, in_valid;
  logic [3:0]    in_op;
  logic [31:0]   in_pc, in_addr, in_wdata, in_wd, fwd_data, mem_rdata;
  logic [4:0]    in_rt, in_wa, fwd_addr;
  logic [TW-1:0] in_tnew;
  logic          mem_ack;
  logic          stall_out, mem_req, out_valid;
  logic [31:0]   mem_addr, mem_wdata, out_pc, out_wd;
  logic [3:0]    mem_we;
  logic [4:0]    out_wa;
  logic [TW-1:0] out_tnew;
  logic [1:0]    out_exc;

  mem_pipe_stage #(.TNEW_W(TW), .MAX_WAIT(MW)) dut (
    .clk(clk), .reset(reset), .flush(flush), .stall_in(stall_in),
    .in_valid(in_valid), .in_op(in_op), .in_pc(in_pc), .in_addr(in_addr),
    .in_wdata(in_wdata), .in_wd(in_wd), .in_rt(in_rt), .in_wa(in_wa),
    .in_tnew(in_tnew), .fwd_addr(fwd_addr), .fwd_data(fwd_data),
    .stall_out(stall_out), .mem_req(mem_req), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_we(mem_we), .mem_ack(mem_ack),
    .mem_rdata(mem_rdata), .out_valid(out_valid), .out_pc(out_pc),
    .out_wa(out_wa), .out_wd(out_wd), .out_tnew(out_tnew), .out_exc(out_exc)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;
  bit chk_en = 1'b0;

  task automatic cmp(input string nm, input logic [31:0] a, input logic [31:0] e);
    n_vec++;
    if (a !== e) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", nm, a, e, $time);
    end
  endtask

  // ---------------- reference model ----------------
  function automatic int sz(input logic [3:0] op);
    case (op)
      4'd1, 4'd2, 4'd6: return 1;
      4'd3, 4'd4, 4'd7: return 2;
      4'd5, 4'd8:       return 4;
      default:          return 0;
    endcase
  endfunction
  function automatic bit is_ld(input logic [3:0] op);
    return (op >= 4'd1) && (op <= 4'd5);
  endfunction
  function automatic bit algn(input logic [3:0] op, input logic [31:0] a);
    if (sz(op) == 0) return 1'b1;
    return (int'(a[1:0]) % sz(op)) == 0;
  endfunction
  function automatic logic [31:0] ldval(input logic [3:0] op, input logic [31:0] a,
                                        input logic [31:0] rd);
    int n, off;
    logic [31:0] mask, v;
    n    = sz(op);
    off  = (n == 4) ? 0 : int'(a[1:0]);
    mask = (n == 4) ? 32'hFFFF_FFFF : ((32'd1 << (8 * n)) - 32'd1);
    v    = (rd >> (8 * off)) & mask;
    if ((op == 4'd1 || op == 4'd3) && v[8 * n - 1]) v = v | ~mask;
    return v;
  endfunction
  function automatic logic [3:0] stwe(input logic [3:0] op, input logic [31:0] a);
    int n, off, w;
    n   = sz(op);
    off = (n == 4) ? 0 : int'(a[1:0]);
    w   = ((1 << n) - 1) << off;
    return 4'(w);
  endfunction
  function automatic logic [31:0] stdat(input logic [3:0] op, input logic [31:0] d);
    if (sz(op) == 1) return {24'b0, d[7:0]} * 32'h0101_0101;
    if (sz(op) == 2) return {16'b0, d[15:0]} * 32'h0001_0001;
    return d;
  endfunction
  function automatic logic [TW-1:0] tdec(input logic [TW-1:0] t);
    return (t == 0) ? TW'(0) : TW'(t - 1);
  endfunction

  bit            m_busy, m_got, m_kill;
  logic [3:0]    m_op;
  logic [31:0]   m_addr, m_sd, m_pc, m_rd;
  logic [4:0]    m_wa;
  logic [TW-1:0] m_tnew;
  int            m_waited;
  bit            e_valid;
  logic [31:0]   e_pc, e_wd;
  logic [4:0]    e_wa;
  logic [TW-1:0] e_tnew;
  logic [1:0]    e_exc;

  function automatic bit m_req();
    return !reset && m_busy && !m_got && (m_waited < MW);
  endfunction
  function automatic bit m_tmo();
    return m_busy && !m_got && (m_waited >= MW);
  endfunction
  function automatic bit m_done();
    return m_busy && !stall_in && (m_got || (m_req() && mem_ack) || m_tmo());
  endfunction
  function automatic bit exp_stall();
    if (reset) return 1'b0;
    if (m_busy) return !m_done();
    return stall_in || (in_valid && sz(in_op) != 0 && algn(in_op, in_addr) && !flush);
  endfunction

  always @(posedge clk) begin
    if (reset) begin
      m_busy <= 0; m_got <= 0; m_kill <= 0; m_waited <= 0;
      m_op <= 0; m_addr <= 0; m_sd <= 0; m_pc <= 0; m_rd <= 0; m_wa <= 0; m_tnew <= 0;
      e_valid <= 0; e_pc <= 0; e_wa <= 0; e_wd <= 0; e_tnew <= 0; e_exc <= 0;
    end else if (!m_busy) begin
      if (flush) begin
        e_valid <= 0; e_pc <= 0; e_wa <= 0; e_wd <= 0; e_tnew <= 0; e_exc <= 0;
      end else if (!stall_in) begin
        if (in_valid && sz(in_op) != 0) begin
          if (algn(in_op, in_addr)) begin
            m_busy <= 1; m_got <= 0; m_kill <= 0; m_waited <= 0;
            m_op <= in_op; m_addr <= in_addr; m_pc <= in_pc; m_wa <= in_wa; m_tnew <= in_tnew;
            m_sd <= (fwd_addr == in_rt && fwd_addr != 0) ? fwd_data : in_wdata;
            e_valid <= 0; e_pc <= 0; e_wa <= 0; e_wd <= 0; e_tnew <= 0; e_exc <= 0;
          end else begin
            e_valid <= 1; e_pc <= in_pc; e_wa <= 0; e_wd <= 0;
            e_tnew <= tdec(in_tnew); e_exc <= is_ld(in_op) ? 2'b01 : 2'b10;
          end
        end else begin
          e_valid <= in_valid; e_pc <= in_pc; e_wa <= in_wa; e_wd <= in_wd;
          e_tnew <= tdec(in_tnew); e_exc <= 0;
        end
      end
    end else if (m_done()) begin
      m_busy <= 0; m_kill <= 0; m_got <= 0;
      if (m_kill || flush) begin
        e_valid <= 0; e_pc <= 0; e_wa <= 0; e_wd <= 0; e_tnew <= 0; e_exc <= 0;
      end else if (m_tmo()) begin
        e_valid <= 1; e_pc <= m_pc; e_wa <= 0; e_wd <= 0; e_tnew <= tdec(m_tnew); e_exc <= 2'b11;
      end else begin
        e_valid <= 1; e_pc <= m_pc; e_tnew <= tdec(m_tnew); e_exc <= 0;
        e_wa <= is_ld(m_op) ? m_wa : 5'd0;
        e_wd <= is_ld(m_op) ? ldval(m_op, m_addr, m_got ? m_rd : mem_rdata) : 32'd0;
      end
    end else begin
      if (flush) m_kill <= 1;
      if (m_req() && mem_ack) begin
        m_got <= 1; m_rd <= mem_rdata;
      end else if (m_req()) begin
        m_waited <= m_waited + 1;
      end
    end
  end

  // Per-cycle comparison of every DUT output against the model
  always @(negedge clk) begin : compare
    bit r;
    if (chk_en) begin
      r = m_req();
      cmp("stall_out", 32'(stall_out), 32'(exp_stall()));
      cmp("mem_req",   32'(mem_req),   32'(r));
      cmp("mem_we",    32'(mem_we),    32'((r && !is_ld(m_op)) ? stwe(m_op, m_addr) : 4'd0));
      if (r) begin
        cmp("mem_addr", mem_addr, m_addr & 32'hFFFF_FFFC);
        if (!is_ld(m_op)) cmp("mem_wdata", mem_wdata, stdat(m_op, m_sd));
      end
      cmp("out_valid", 32'(out_valid), 32'(e_valid));
      cmp("out_pc",    out_pc, e_pc);
      cmp("out_wa",    32'(out_wa), 32'(e_wa));
      cmp("out_wd",    out_wd, e_wd);
      cmp("out_tnew",  32'(out_tnew), 32'(e_tnew));
      cmp("out_exc",   32'(out_exc), 32'(e_exc));
    end
  end

  // ---------------- stimulus ----------------
  task automatic step();
    @(posedge clk); #1;
  endtask
  task automatic clr_in();
    flush = 0; stall_in = 0; in_valid = 0; in_op = 0; in_pc = 0; in_addr = 0;
    in_wdata = 0; in_wd = 0; in_rt = 0; in_wa = 0; in_tnew = 0;
    fwd_addr = 0; fwd_data = 0; mem_ack = 0; mem_rdata = 0;
  endtask
  task automatic put(input logic [3:0] op, input logic [31:0] a, input logic [4:0] wa,
                     input logic [31:0] pc);
    in_valid = 1; in_op = op; in_addr = a; in_wa = wa; in_pc = pc;
  endtask
  task automatic do_load(input logic [3:0] op, input logic [31:0] a, input logic [31:0] rd);
    put(op, a, 5'd4, 32'h10);
    step();
    mem_ack = 1; mem_rdata = rd;
    step();
    mem_ack = 0; in_valid = 0;
    @(negedge clk);
  endtask

  initial begin
    clr_in();
    reset = 1;
    put(4'd5, 32'h0, 5'd1, 32'h4);   // pending lw must not matter under reset
    repeat (2) step();
    chk_en = 1;
    @(negedge clk);
    cmp("rst_stall", 32'(stall_out), 0);
    cmp("rst_req",   32'(mem_req), 0);
    cmp("rst_valid", 32'(out_valid), 0);
    cmp("rst_wd",    out_wd, 0);
    step(); reset = 0; clr_in();

    // pass-through, downstream hold, flush beating stall
    put(4'd0, 32'h0, 5'd3, 32'h1000); in_wd = 32'h55; in_tnew = 3'd5;
    step(); @(negedge clk);
    cmp("pt_wd", out_wd, 32'h55); cmp("pt_wa", 32'(out_wa), 3);
    cmp("pt_tnew", 32'(out_tnew), 4); cmp("pt_stall", 32'(stall_out), 0);
    step(); stall_in = 1; in_wd = 32'h66; in_tnew = 3'd0;
    @(negedge clk); cmp("hold_wd", out_wd, 32'h55);
    step(); stall_in = 0;
    step(); @(negedge clk);
    cmp("pt2_wd", out_wd, 32'h66); cmp("pt2_tnew_sat", 32'(out_tnew), 0);
    step(); flush = 1; stall_in = 1;
    step(); @(negedge clk); cmp("flush_valid", 32'(out_valid), 0); cmp("flush_wd", out_wd, 0);
    step(); clr_in();

    // lw with ack in the third WAIT cycle
    put(4'd5, 32'h100, 5'd8, 32'h2000);
    @(negedge clk); cmp("lw_stall_idle", 32'(stall_out), 1); cmp("lw_req_idle", 32'(mem_req), 0);
    step(); @(negedge clk); cmp("lw_req1", 32'(mem_req), 1); cmp("lw_addr", mem_addr, 32'h100);
    step(); @(negedge clk); cmp("lw_req2", 32'(mem_req), 1); cmp("lw_stall2", 32'(stall_out), 1);
    step(); mem_ack = 1; mem_rdata = 32'hDEADBEEF;
    @(negedge clk); cmp("lw_req3", 32'(mem_req), 1); cmp("lw_stall_ack", 32'(stall_out), 0);
    step(); mem_ack = 0; in_valid = 0;
    @(negedge clk); cmp("lw_wd", out_wd, 32'hDEADBEEF); cmp("lw_wa", 32'(out_wa), 8);
    cmp("lw_req_after", 32'(mem_req), 0);
    step(); clr_in();

    // sb with forwarded store data
    put(4'd6, 32'h203, 5'd7, 32'h2100); in_wdata = 32'h12345678; in_rt = 5; fwd_addr = 5; fwd_data = 32'hAB;
    step(); fwd_data = 0; in_wdata = 0;
    @(negedge clk);
    cmp("sb_we", 32'(mem_we), 32'h8); cmp("sb_wdata", mem_wdata, 32'hABABABAB);
    cmp("sb_addr", mem_addr, 32'h200);
    step(); mem_ack = 1;
    step(); mem_ack = 0; in_valid = 0;
    @(negedge clk); cmp("sb_wd", out_wd, 0); cmp("sb_wa", 32'(out_wa), 0); cmp("sb_valid", 32'(out_valid), 1);
    step(); clr_in();

    // byte loads with sign/zero extension, misaligned lh
    do_load(4'd1, 32'h2, 32'h0080_0000); cmp("lb_wd", out_wd, 32'hFFFFFF80);
    step();
    do_load(4'd2, 32'h2, 32'h0080_0000); cmp("lbu_wd", out_wd, 32'h00000080);
    step();
    put(4'd3, 32'h1, 5'd6, 32'h2200);
    @(negedge clk); cmp("lh_mis_req", 32'(mem_req), 0); cmp("lh_mis_stall", 32'(stall_out), 0);
    step(); in_valid = 0;
    @(negedge clk); cmp("lh_mis_exc", 32'(out_exc), 1); cmp("lh_mis_wa", 32'(out_wa), 0);
    cmp("lh_mis_pc", out_pc, 32'h2200);
    step(); clr_in();

    // lw that is never acked: timeout
    put(4'd5, 32'h300, 5'd9, 32'h3000);
    step();
    for (int k = 0; k < 4; k++) begin
      @(negedge clk); cmp("tmo_req_hi", 32'(mem_req), 1);
      step();
    end
    mem_ack = 1;
    @(negedge clk); cmp("tmo_req_lo", 32'(mem_req), 0); cmp("tmo_stall", 32'(stall_out), 0);
    step(); mem_ack = 0; in_valid = 0;
    @(negedge clk); cmp("tmo_exc", 32'(out_exc), 3); cmp("tmo_wa", 32'(out_wa), 0);
    cmp("tmo_pc", out_pc, 32'h3000);
    step(); clr_in();

    // sw killed by a flush while waiting
    put(4'd8, 32'h40, 5'd2, 32'h4000); in_wdata = 32'hCAFEF00D;
    step(); flush = 1;
    step(); flush = 0;
    step(); mem_ack = 1;
    @(negedge clk); cmp("sw_we", 32'(mem_we), 32'hF); cmp("sw_wdata", mem_wdata, 32'hCAFEF00D);
    step(); mem_ack = 0; in_valid = 0;
    @(negedge clk); cmp("kill_valid", 32'(out_valid), 0); cmp("kill_pc", out_pc, 0);
    cmp("kill_req", 32'(mem_req), 0);
    step(); clr_in();

    // reset while waiting, late ack ignored
    put(4'd5, 32'h500, 5'd10, 32'h5000);
    step(); step(); reset = 1;
    @(negedge clk); cmp("rstw_req", 32'(mem_req), 0);
    step(); reset = 0; clr_in(); mem_ack = 1; mem_rdata = 32'h11111111;
    @(negedge clk); cmp("rstw_req2", 32'(mem_req), 0); cmp("rstw_valid", 32'(out_valid), 0);
    step(); @(negedge clk); cmp("rstw_wd", out_wd, 0); cmp("rstw_wa", 32'(out_wa), 0);
    step(); clr_in();

    // randomized traffic, model compare runs every cycle
    for (int n = 0; n < 3000; n++) begin
      int ack_pct;
      step();
      ack_pct   = ((n / 500) % 2) ? 8 : 45;
      reset     = ($urandom_range(0, 255) == 0);
      flush     = ($urandom_range(0, 15) == 0);
      stall_in  = ($urandom_range(0, 3) == 0);
      in_valid  = ($urandom_range(0, 3) != 0);
      in_op     = 4'($urandom_range(0, 15) < 12 ? $urandom_range(0, 8) : $urandom_range(9, 15));
      in_pc     = $urandom;
      in_addr   = $urandom;
      in_wdata  = $urandom;
      in_wd     = $urandom;
      in_rt     = 5'($urandom_range(0, 31));
      in_wa     = 5'($urandom_range(0, 31));
      in_tnew   = TW'($urandom_range(0, 7));
      fwd_addr  = $urandom_range(0, 1) ? in_rt : 5'($urandom_range(0, 31));
      fwd_data  = $urandom;
      mem_ack   = ($urandom_range(0, 99) < ack_pct);
      mem_rdata = $urandom;
    end
    step(); clr_in(); reset = 0;
    repeat (3) step();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule

// File: doc/mem_pipe_stage.md
MEM_PIPE_STAGE -- requirements
Module: mem_pipe_stage

Interface
REQ-001 Parameter TNEW_W, default 3, Tnew field width.
REQ-002 Parameter MAX_WAIT, default 15, max WAIT cycles before timeout (1..255).
REQ-003 clk  in  1  clock; reset  in  1  reset, synchronous, active-high.
REQ-004 flush  in  1  kill current stage contents; stall_in  in  1  downstream stall.
REQ-005 in_valid  in  1  stage holds instruction; in_op  in  4  0 none, 1 lb, 2 lbu, 3 lh, 4 lhu, 5 lw, 6 sb, 7 sh, 8 sw, 9-15 treated as none.
REQ-006 in_pc, in_addr, in_wdata, in_wd  in  32 each  PC, byte address, store data, non-load writeback data.
REQ-007 in_rt, in_wa  in  5 each  store source register, destination register; in_tnew  in  TNEW_W.
REQ-008 fwd_addr  in  5, fwd_data  in  32  writeback-stage forward source.
REQ-009 stall_out  out  1  stage busy, upstream holds.
REQ-010 mem_req  out  1; mem_addr  out  32 (bits 1:0 zero); mem_wdata  out  32; mem_we  out  4; mem_ack  in  1; mem_rdata  in  32.
REQ-011 out_valid  out  1; out_pc  out  32; out_wa  out  5; out_wd  out  32; out_tnew  out  TNEW_W; out_exc  out  2 (01 misaligned load, 10 misaligned store, 11 timeout).

Function
REQ-012 States: IDLE, WAIT; encoding free.
REQ-013 Memory op = in_valid and in_op 1..8; aligned = halfword addr[0]==0, word addr[1:0]==0.
REQ-014 Store data source: fwd_data if fwd_addr==in_rt and fwd_addr!=0, else in_wdata; sampled when entering WAIT.
REQ-015 IDLE, non-memory op or !in_valid, !stall_in: outputs load pass-through (out_wd=in_wd, out_wa=in_wa, out_valid=in_valid), one-cycle latency, stall_out=0.
REQ-016 IDLE, misaligned memory op, !stall_in: no mem_req; outputs load bubble (out_wa=0, out_wd=0) with out_valid=1, out_pc=in_pc, out_exc set.
REQ-017 IDLE, aligned memory op: stall_out=1; latch op, addr[1:0], store data, wa, pc, tnew; next state WAIT; wait counter cleared.
REQ-018 WAIT: mem_req=1, mem_addr={addr[31:2],2'b00}; mem_we 0 for loads; sb one-hot lane addr[1:0], data replicated x4; sh 0011/1100 by addr[1], data replicated x2; sw 1111.
REQ-019 WAIT, mem_ack & !stall_in: outputs load, state->IDLE, stall_out=0 same cycle; else stall_out=1.
REQ-020 Load result: lane selected by addr[1:0]; lb/lh sign-extend, lbu/lhu zero-extend, lw as is; stores write out_wd=0, out_wa=0.
REQ-021 mem_ack while stall_in: stay WAIT with mem_req=0, captured rdata held, complete when stall_in drops; mem_ack outside WAIT ignored.
REQ-022 Wait counter increments each WAIT cycle without ack; at MAX_WAIT: mem_req drops, bubble output with out_exc=11, state IDLE.
REQ-023 out_tnew = in_tnew-1 saturating at 0 (latched value in WAIT).
REQ-024 stall_in in IDLE: output registers hold; no state change.
REQ-025 flush in IDLE: output registers cleared next edge, no request issued.
REQ-026 flush in WAIT: kill flag set; transaction runs to ack/timeout; result replaced by cleared outputs; kill flag cleared on leaving WAIT.
REQ-027 flush and stall_in together: flush wins for output registers.

Reset
REQ-028 reset: state IDLE, counter 0, kill 0, mem_req 0, mem_we 0, stall_out 0, all out_* 0 next edge, overriding every other input.
REQ-029 reset in WAIT: request abandoned, mem_ack at that or following edges ignored.

Verification
REQ-030 lw addr 0x100, wa=8, ack after 3 WAIT cycles, rdata 0xDEADBEEF -> mem_req 3 cycles, out_wd 0xDEADBEEF, out_wa 8, stall_out low only in ack cycle.
REQ-031 sb addr 0x203, in_wdata 0x12345678, fwd_addr=in_rt=5, fwd_data 0xAB -> mem_we 1000, mem_wdata 0xABABABAB, mem_addr 0x200.
REQ-032 lb addr 0x2, rdata 0x00800000 -> out_wd 0xFFFFFF80; lbu same -> 0x00000080; lh addr 1 -> no req, out_exc 01.
REQ-033 lw, ack never, MAX_WAIT=4 -> mem_req drops after 4 cycles, out_exc 11, out_wa 0.
REQ-034 sw in WAIT, flush pulse, ack later -> write issued with mem_we 1111, output cleared, state IDLE.
REQ-035 reset asserted in WAIT -> mem_req 0 next cycle, out_* 0, late ack causes no output change.
